// File: rtl/cdc_in_arbiter.sv
// ============================================================================
// cdc_in_arbiter : round-robin burst arbiter sharing the USB CDC IN byte stream
//                  between NUM_REQ requesters, with a one-deep output register.
// Optional build macro: CDC_ARB_TAG_EN (prefix each burst with a tag byte).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module cdc_in_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
`ifdef CDC_ARB_TAG_EN
    , ST_TAG = 2'd2
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [2:0]         rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;

  logic                 ld;
  logic                 xfer;
  logic                 owner_valid;
  logic [2:0]           owner_idx;
  logic [7:0]           owner_byte;
  logic [2*NUM_REQ-1:0] rot_dbl;
  logic [NUM_REQ-1:0]   rot_valid;
  logic                 found;
  logic [2:0]           pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [CNT_W-1:0]     cnt_inc;

  function automatic logic [2:0] wrap_idx(input logic [3:0] v);
    return (v >= 4'(NUM_REQ)) ? 3'(v - 4'(NUM_REQ)) : 3'(v);
  endfunction

  assign ld          = ~valid_q | in_ready_i;
  assign req_ready_o = (state_q == ST_GRANT && ld) ? grant_q : '0;
  assign xfer        = |(req_valid_i & req_ready_o);
  assign owner_valid = |(req_valid_i & grant_q);
  assign cnt_inc     = cnt_q + CNT_W'(1);

  always_comb begin
    owner_idx  = '0;
    owner_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        owner_idx  = 3'(k);
        owner_byte = req_data_i[8*k +: 8];
      end
    end
  end

  // Rotate the request vector so bit 0 is the rr pointer, then take the lowest set bit.
  assign rot_dbl   = {req_valid_i, req_valid_i} >> rr_q;
  assign rot_valid = rot_dbl[NUM_REQ-1:0];

  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot_valid[i]) begin
        found    = 1'b1;
        pick_idx = wrap_idx(4'(rr_q) + 4'(i));
      end
    end
  end

  assign pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (ld) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          grant_d = pick_oh;
          cnt_d   = '0;
`ifdef CDC_ARB_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_GRANT;
`endif
        end
      end
`ifdef CDC_ARB_TAG_EN
      ST_TAG: begin
        if (ld) begin
          data_d  = {4'hA, 1'b0, owner_idx};
          valid_d = 1'b1;
          state_d = ST_GRANT;
        end
      end
`endif
      ST_GRANT: begin
        if (xfer) begin
          data_d  = owner_byte;
          valid_d = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            state_d = ST_IDLE;
            grant_d = '0;
            rr_d    = wrap_idx(4'(owner_idx) + 4'd1);
            cnt_d   = '0;
          end
        end else if (ld && !owner_valid) begin
          // Owner idle while the path was free: give the stream to someone else.
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = wrap_idx(4'(owner_idx) + 4'd1);
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign in_data_o  = data_q;
  assign in_valid_o = valid_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

`default_nettype wire
